// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: one requester's request/response bundle for alu_arbiter.
//   req_valid/req_ready : request handshake (requester drives valid)
//   req_a, req_b        : operands, WIDTH bits
//   req_sel             : 3-bit opcode
//   rsp_valid/rsp_ready : response handshake (arbiter drives valid)
//   rsp_data, rsp_carry : registered result and carry
// Modports: master = requester side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [2:0]       req_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_carry;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_carry
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_carry
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one WIDTH-bit ALU between two requesters.
// Ports:
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   port0  : alu_arbiter_if.slave, requester 0 (req0_* / rsp0_*)
//   port1  : alu_arbiter_if.slave, requester 1 (req1_* / rsp1_*)
// Sequence per operation: IDLE (accept) -> EXEC (compute into result regs)
// -> RESP (hold result until consumer ready).
// Opcodes: 000 add, 001 sub, 010 ~a, 011 a&b, 100 a|b, 101 a^b,
//          110 a<<1, 111 a>>1. Carry is always the carry-out of a+b.
// Build option: define ALU_ARB_ROUND_ROBIN_EN for round-robin contention;
// otherwise port 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave port0,
  alu_arbiter_if.slave port1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic             grant_q;      // 1 = port 1 owns the current operation
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       sel_q;
  logic             rsp0_valid_q;
  logic             rsp1_valid_q;
  logic [WIDTH-1:0] rsp0_data_q;
  logic [WIDTH-1:0] rsp1_data_q;
  logic             rsp0_carry_q;
  logic             rsp1_carry_q;
`ifdef ALU_ARB_ROUND_ROBIN_EN
  logic             last_grant;
`endif

  logic             pick;         // port chosen this cycle in IDLE
  logic             accept;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             rsp_hs;

  always_comb begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
    pick = (port0.req_valid && port1.req_valid) ? ~last_grant : port1.req_valid;
`else
    pick = ~port0.req_valid;
`endif
    accept = (state == IDLE) && !rst && (port0.req_valid || port1.req_valid);
    port0.req_ready = accept && !pick;
    port1.req_ready = accept && pick;
  end

  always_comb begin
    sum = {1'b0, a_q} + {1'b0, b_q};
    unique case (sel_q)
      3'b000:  alu_res = sum[WIDTH-1:0];
      3'b001:  alu_res = a_q - b_q;
      3'b010:  alu_res = ~a_q;
      3'b011:  alu_res = a_q & b_q;
      3'b100:  alu_res = a_q | b_q;
      3'b101:  alu_res = a_q ^ b_q;
      3'b110:  alu_res = a_q << 1;
      default: alu_res = a_q >> 1;
    endcase
  end

  assign rsp_hs = grant_q ? port1.rsp_ready : port0.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      grant_q      <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
      rsp0_carry_q <= 1'b0;
      rsp1_carry_q <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
      last_grant   <= 1'b1;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q     <= pick ? port1.req_a   : port0.req_a;
            b_q     <= pick ? port1.req_b   : port0.req_b;
            sel_q   <= pick ? port1.req_sel : port0.req_sel;
            grant_q <= pick;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (grant_q) begin
            rsp1_data_q  <= alu_res;
            rsp1_carry_q <= sum[WIDTH];
            rsp1_valid_q <= 1'b1;
          end else begin
            rsp0_data_q  <= alu_res;
            rsp0_carry_q <= sum[WIDTH];
            rsp0_valid_q <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            last_grant   <= grant_q;
`endif
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign port0.rsp_valid = rsp0_valid_q;
  assign port1.rsp_valid = rsp1_valid_q;
  assign port0.rsp_data  = rsp0_data_q;
  assign port1.rsp_data  = rsp1_data_q;
  assign port0.rsp_carry = rsp0_carry_q;
  assign port1.rsp_carry = rsp1_carry_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares a single 32-bit ALU datapath between two independent requesters. Each requester issues one operation (operands plus 3-bit opcode) over a valid/ready handshake; the arbiter grants one request at a time, sequences it through operand capture, execute and response, and returns the registered result and carry to the granted requester only. It sits between the two issuing units and the ALU, so neither unit needs a private ALU.

## Interface
- `WIDTH`, 32: operand/result width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: port 0 request valid.
- `req0_ready` out 1: port 0 request accepted this cycle.
- `req0_a`, `req0_b` in WIDTH: port 0 operands.
- `req0_sel` in 3: port 0 opcode.
- `rsp0_valid` out 1: port 0 result valid.
- `rsp0_ready` in 1: port 0 consumer ready.
- `rsp0_data` out WIDTH: port 0 result.
- `rsp0_carry` out 1: port 0 carry.
- `req1_*`, `rsp1_*`: identical set for port 1.

## Operation
- Opcodes:
  - 000 add
  - 001 sub (a-b, modulo 2^WIDTH)
  - 010 ~a
  - 011 a&b
  - 100 a|b
  - 101 a^b
  - 110 a<<1
  - 111 a>>1 (logical)
- Carry is bit WIDTH of the (WIDTH+1)-bit sum {0,a}+{0,b}, computed for every opcode. It is not limited to add.
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant is combinational from the request valids and `last_grant`.
  - `reqN_ready` = 1 only for the granted port, and only when its valid is 1.
  - On the handshake: latch a, b, sel and grant index, then go to EXEC.
  - With no valid: stay in IDLE, both readies 0.
- EXEC: one cycle. The ALU output and carry from the latched operands are written to the result registers, then go to RESP.
- RESP:
  - `rspN_valid` = 1 for the granted port only. The other port's `rsp_valid` = 0.
  - Data and carry are held stable until `rspN_ready` = 1.
  - On the response handshake, go to IDLE and set `last_grant` to the served port.
- No new request is accepted outside IDLE. Both `req*_ready` = 0 in EXEC and RESP.
- Arbitration when both valids are high in IDLE: see Configuration. When exactly one valid is high, that port is granted.
- Requester rule: once `reqN_valid` is asserted, the requester holds it and its payload stable until `reqN_ready`. The arbiter does not check this.
- Reset reaches every state and abandons any in-flight operation; no response is ever issued for it.

## Timing
- Request handshake at edge T. EXEC occupies T..T+1. `rsp_valid` is high from the cycle after edge T+1, i.e. two cycles after acceptance.
- `rsp_ready` already high when `rsp_valid` rises: one RESP cycle, back in IDLE, next accept possible at edge T+3. Peak throughput is 1 operation per 3 cycles.
- `req_ready` is combinational from `req_valid` and state. There is no combinational path from `req_*` to `rsp_*`.
- Reset values:
  - state = IDLE, `last_grant` = 1 (port 0 wins the first contention).
  - `rsp0_valid` = `rsp1_valid` = 0.
  - `rsp*_data` = 0, `rsp*_carry` = 0.
  - `req*_ready` = 0 while `rst` is high.
- Response backpressure of any length is legal. The FSM stays in RESP and the other port's requests wait.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined: round-robin arbitration. When both valids are high, the port ≠ `last_grant` is granted.
- Not defined: fixed priority. Port 0 always wins contention. `last_grant` may still be maintained but does not affect the grant.

## Test plan
- Single add: port 0 a=0xFFFF_FFFF, b=1, sel=000, `rsp0_ready`=1. Required: `rsp0_data`=0, `rsp0_carry`=1, `rsp0_valid` exactly 2 cycles after accept. Port 1 sees no response.
- Opcode sweep on port 1 with a=0xF0F0_0001, b=0x0000_0003:
  - sub → 0xF0EF_FFFE
  - not → 0x0F0F_FFFE
  - and → 0x1
  - or → 0xF0F0_0003
  - xor → 0xF0F0_0002
  - sll → 0xE1E0_0002
  - srl → 0x7878_0000
- Contention: both ports hold valid for 4 requests each, rsp_ready=1.
  - With the macro: grants alternate 0,1,0,1,…
  - Without it: all four port-0 requests complete before any port-1 request.
- Backpressure: `rsp0_ready`=0 for 5 cycles. Required: `rsp0_valid`/data/carry stable, both `req_ready` 0 throughout. After `rsp0_ready`=1: IDLE, and a pending port-1 request is accepted the next cycle.
- Reset mid-op: assert `rst` in EXEC. Required: no `rsp*_valid` ever issued for that request, all outputs at reset values next cycle, and a new request then completes normally.
- Idle: no valids for 10 cycles. Required: both readies and both `rsp_valid` remain 0.
